seg_scan_mux: RTL
=================

// Module: seg_scan_mux
// PURPOSE
//  Time-multiplexes a DIGITS-wide hex value onto the shared-cathode 7-segment display.
//  Sits directly upstream of the nibble-to-segment decoder.
//  - Each refresh slot selects one digit and presents its 4-bit nibble on digit_num.
//  - digit_num feeds the decoder; the active-low anode drives the board.
//  - New values are double-buffered and applied only at frame boundaries, so a frame never shows mixed digits.
// PARAMETERS
//  DIGITS       4        number of digits scanned; digit 0 = rightmost = value[3:0]
//  REFRESH_DIV  100000   clk cycles per digit slot (1 kHz/digit at 100 MHz); must be >= 2
// PORTS
//  clk         in   1           system clock, all logic on rising edge
//  rst_n       in   1           synchronous reset, active-low
//  en          in   1           1 = scan active; 0 = all anodes off, counters keep running
//  value       in   4*DIGITS    hex value to show; sampled only when load=1
//  dp_mask     in   DIGITS      decimal point per digit (1 = lit); sampled with value
//  load        in   1           1-cycle strobe: capture value/dp_mask into pending buffer
//  digit_num   out  4           nibble of the currently selected digit, to decoder
//  anodes_n    out  DIGITS      active-low anode enables, at most one bit low
//  dp_n        out  1           active-low decimal point for the selected digit
//  frame_done  out  1           1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge) clears:
//    - prescaler=0, idx=0, shadow=0, shadow_dp=0, pending_valid=0
//    - outputs: anodes_n=all 1, digit_num=0, dp_n=1, frame_done=0
//  - Prescaler counts 0..REFRESH_DIV-1 and wraps to 0.
//    - tick = (prescaler==REFRESH_DIV-1).
//  - On tick, idx advances 0,1,..,DIGITS-1,0 (wrap).
//    - Frame boundary = tick with idx==DIGITS-1.
//  - load=1: pending<=value, pending_dp<=dp_mask, pending_valid<=1.
//    - Back-to-back loads: the last one wins.
//  - At a frame boundary with pending_valid=1: shadow<=pending and pending_valid<=0.
//  - Load and frame boundary in the same cycle: shadow takes the incoming value directly (bypass).
//    - pending_valid ends at 0.
//  - Outputs are registered, one cycle after the idx/shadow state:
//    - digit_num = shadow[4*idx+:4]
//    - dp_n = ~shadow_dp[idx]
//    - anodes_n = ~(1<<idx) when en=1 and the digit is not blanked, else all 1
//  - frame_done is registered from the frame boundary: high exactly 1 cycle per frame.
//  - en=0 blanks the anodes only.
//    - The prescaler, idx and load path continue.
//    - Re-enabling resumes at the current idx with no restart.
//  - Reset asserted mid-frame: the rules above apply at that edge, and any pending load is discarded.
//  - Full frame period = DIGITS*REFRESH_DIV cycles.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    - Digit k>0 is blanked (anode high, dp_n=1) when shadow nibbles k..DIGITS-1 are all 0.
//    - Digit 0 is never blanked.
//    - If shadow_dp[k]=1, digit k is shown and blanking stops at k.
//  LEADING_ZERO_BLANK_EN undefined:
//    - No digit is ever blanked, so every digit of an all-zero value shows 0.
// TESTING  (bench: DIGITS=4, REFRESH_DIV=4)
//  1. Reset, en=1, load value=16'h1234:
//     -> after the next frame boundary, digit_num cycles 4,3,2,1.
//     -> anodes_n cycles 1110,1101,1011,0111, 4 clk per slot.
//  2. Load 16'hABCD mid-frame (idx=1):
//     -> the rest of the frame still shows the old value.
//     -> the new value appears from idx 0 of the next frame.
//     -> frame_done pulses once every 16 clk.
//  3. Load on the exact frame-boundary cycle:
//     -> the new value is shown from the following slot 0.
//     -> pending_valid=0 afterwards.
//  4. en=0 for 10 clk:
//     -> anodes_n=1111 throughout.
//     -> on en=1, scan resumes at the idx the counters reached.
//  5. Assert rst_n=0 for 1 clk mid-slot with a load pending:
//     -> the next cycle shows anodes_n=1111, digit_num=0, frame_done=0.
//     -> the pending value is never displayed.
//  6. LEADING_ZERO_BLANK_EN, value=16'h0040, dp_mask=0:
//     -> digits 3 and 2 blanked; digits 1 and 0 show 4 and 0.
//     -> with dp_mask=4'b1000, all four digits are shown.

Source files
------------

// File: rtl/seg_scan_mux.sv
// +----------------------------------------------------------------------------+
// | Module      : seg_scan_mux                                                 |
// | Description : Time-multiplexed scan of a DIGITS-wide hex value onto a      |
// |               shared-cathode 7-segment display. Presents the selected      |
// |               nibble to the downstream segment decoder and drives active-  |
// |               low anode / decimal-point enables. New values are double-    |
// |               buffered and committed only at frame boundaries.             |
// |               Optional feature macro: LEADING_ZERO_BLANK_EN                |
// |               (blank leading zero digits, digit 0 never blanked).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  load,
  output logic [3:0]            digit_num,
  output logic [DIGITS-1:0]     anodes_n,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DIGITS - 1);

  // Scan state
  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  // Double buffer: pending holds the latest load, shadow is what is displayed
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic [DIGITS-1:0]   pending_dp_q, pending_dp_d;
  logic                pending_valid_q, pending_valid_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  // Registered outputs
  logic [3:0]          digit_num_q, digit_num_d;
  logic [DIGITS-1:0]   anodes_n_q, anodes_n_d;
  logic                dp_n_q, dp_n_d;
  logic                frame_done_q, frame_done_d;

  logic                w_tick;
  logic                w_boundary;
  logic [DIGITS-1:0]   w_blank;
  logic [3:0]          w_sel_nib;
  logic                w_sel_dp;
  logic                w_sel_blank;

  assign w_tick     = (prescaler_q == C_PRE_LAST);
  assign w_boundary = w_tick && (idx_q == C_IDX_LAST);

  // Per-digit blanking mask derived from the displayed (shadow) value
  always_comb begin
    w_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin : g_lzb
      logic zero_run;
      zero_run = 1'b1;
      // Walk from the most significant digit down; a non-zero nibble or a lit
      // decimal point ends the leading-zero run. Digit 0 is never blanked.
      for (int k = DIGITS - 1; k >= 1; k--) begin
        zero_run   = zero_run && (shadow_q[4*k +: 4] == 4'h0) && !shadow_dp_q[k];
        w_blank[k] = zero_run;
      end
    end
`endif
  end

  // Select the nibble, decimal point and blank flag of the current digit
  always_comb begin
    w_sel_nib   = 4'h0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        w_sel_nib   = shadow_q[4*k +: 4];
        w_sel_dp    = shadow_dp_q[k];
        w_sel_blank = w_blank[k];
      end
    end
  end

  // Next-state: prescaler/index advance, load buffering and frame commit
  always_comb begin
    prescaler_d     = w_tick ? '0 : prescaler_q + 1'b1;
    idx_d           = idx_q;
    pending_d       = pending_q;
    pending_dp_d    = pending_dp_q;
    pending_valid_d = pending_valid_q;
    shadow_d        = shadow_q;
    shadow_dp_d     = shadow_dp_q;

    if (w_tick) begin
      idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (load) begin
      pending_d       = value;
      pending_dp_d    = dp_mask;
      pending_valid_d = 1'b1;
    end

    if (w_boundary) begin
      if (load) begin
        // Load coinciding with the boundary goes straight to the display
        shadow_d        = value;
        shadow_dp_d     = dp_mask;
        pending_valid_d = 1'b0;
      end else if (pending_valid_q) begin
        shadow_d        = pending_q;
        shadow_dp_d     = pending_dp_q;
        pending_valid_d = 1'b0;
      end
    end
  end

  // Output next-state: reflects the current idx/shadow, registered below
  always_comb begin
    digit_num_d  = w_sel_nib;
    dp_n_d       = w_sel_blank ? 1'b1 : ~w_sel_dp;
    frame_done_d = w_boundary;
    anodes_n_d   = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((idx_q == IDX_W'(k)) && en && !w_sel_blank) begin
        anodes_n_d[k] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_q     <= '0;
      idx_q           <= '0;
      pending_q       <= '0;
      pending_dp_q    <= '0;
      pending_valid_q <= 1'b0;
      shadow_q        <= '0;
      shadow_dp_q     <= '0;
      digit_num_q     <= 4'h0;
      anodes_n_q      <= '1;
      dp_n_q          <= 1'b1;
      frame_done_q    <= 1'b0;
    end else begin
      prescaler_q     <= prescaler_d;
      idx_q           <= idx_d;
      pending_q       <= pending_d;
      pending_dp_q    <= pending_dp_d;
      pending_valid_q <= pending_valid_d;
      shadow_q        <= shadow_d;
      shadow_dp_q     <= shadow_dp_d;
      digit_num_q     <= digit_num_d;
      anodes_n_q      <= anodes_n_d;
      dp_n_q          <= dp_n_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign digit_num  = digit_num_q;
  assign anodes_n   = anodes_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire
